// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame bit indices and parity helper
package ps2_pkg;
   typedef logic [2:0] ps2_state_t;
   localparam ps2_state_t IDLE      = 3'd0;
   localparam ps2_state_t INHIBIT   = 3'd1;
   localparam ps2_state_t REQ       = 3'd2;
   localparam ps2_state_t SEND      = 3'd3;
   localparam ps2_state_t ACK       = 3'd4;
   localparam ps2_state_t WAIT_IDLE = 3'd5;
   localparam int PARITY_BIT = 9;
   localparam int STOP_BIT   = 10;
   localparam int ACK_BIT    = 11;
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake and frame status between a client and ps2_host_tx
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       nack;
   modport master (output tx_valid, tx_data, input tx_ready, busy, done, nack);
   modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, nack);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 pins plus a clock falling-edge strobe
module ps2_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);
   logic [1:0] c_ff, d_ff;
   logic       c_prev;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         c_ff   <= 2'b11;
         d_ff   <= 2'b11;
         c_prev <= 1'b1;
      end else begin
         c_ff   <= {c_ff[0], ps2_clk_in};
         d_ff   <= {d_ff[0], ps2_data_in};
         c_prev <= c_ff[1];
      end
   assign clk_s    = c_ff[1];
   assign data_s   = d_ff[1];
   assign clk_fall = c_prev & ~c_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with device ACK check.
// Optional frame watchdog enabled by PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_MS = 15
) (
   input  logic        clk,
   input  logic        reset,
   ps2_host_tx_if.slave bus,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe
);
   localparam int INHIBIT_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
   localparam int IW = $clog2(INHIBIT_CYC + 1);
   ps2_state_t state;
   logic [IW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    sh;
   logic          drv, ack_ok, clk_s, data_s, clk_fall, accept, last_inh, wd_exp;
   ps2_line_sync u_sync (
      .clk, .reset, .ps2_clk_in, .ps2_data_in, .clk_s, .data_s, .clk_fall
   );
   assign bus.tx_ready = state == IDLE;
   assign bus.busy     = state != IDLE;
   assign accept       = bus.tx_valid && bus.tx_ready;
   assign last_inh     = state == INHIBIT && cnt == IW'(INHIBIT_CYC - 1);
   assign ps2_clk_oe   = state == INHIBIT || state == REQ;
   // start bit goes low on the last inhibit cycle; in SEND a 0 bit pulls the line
   assign ps2_data_oe  = last_inh || state == REQ || (state == SEND && !drv);
`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int WD_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam int WW = $clog2(WD_CYC + 1);
   logic [WW-1:0] wd;
   logic          in_frame;
   assign in_frame = state inside {INHIBIT, REQ, SEND, ACK};
   assign wd_exp   = in_frame && wd == WW'(WD_CYC - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) wd <= '0;
      else if (accept) wd <= '0;
      else if (in_frame && wd != WW'(WD_CYC)) wd <= wd + 1'b1;
`else
   assign wd_exp = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         sh       <= '1;
         drv      <= 1'b1;
         ack_ok   <= 1'b0;
         bus.done <= 1'b0;
         bus.nack <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.nack <= 1'b0;
         if (wd_exp) begin
            state    <= IDLE;
            drv      <= 1'b1;
            bus.nack <= 1'b1;
         end else
            case (state)
               IDLE: if (accept) begin
                  state <= INHIBIT;
                  cnt   <= '0;
                  sh    <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
               end
               INHIBIT: if (last_inh) state <= REQ; else cnt <= cnt + 1'b1;
               REQ: begin
                  state   <= SEND;
                  bit_cnt <= '0;
                  drv     <= 1'b0;
               end
               // shift in ones so the tenth edge presents the stop bit
               SEND: if (clk_fall) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  drv     <= sh[0];
                  sh      <= {1'b1, sh[9:1]};
                  if (bit_cnt == 4'(STOP_BIT - 1)) state <= ACK;
               end
               ACK: if (clk_fall) begin
                  ack_ok  <= !data_s;
                  bit_cnt <= 4'(ACK_BIT);
                  state   <= WAIT_IDLE;
               end
               WAIT_IDLE: if (clk_s && data_s) begin
                  state    <= IDLE;
                  bus.done <= ack_ok;
                  bus.nack <= !ack_ok;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed tests of ps2_host_tx against a behavioural PS/2 device
module tb_ps2_host_tx;
   logic clk = 0, reset = 0, dev_clk = 1, dev_data = 1;
   logic clk_oe, data_oe, pclk, pdata;
   int checks = 0, failures = 0, n_done = 0, n_nack = 0, n_both = 0;
   ps2_host_tx_if bus();
   assign pclk  = dev_clk & ~clk_oe;
   assign pdata = dev_data & ~data_oe;
   ps2_host_tx #(.CLK_FREQ(1_000_000), .INHIBIT_US(100), .TIMEOUT_MS(2)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .ps2_clk_in(pclk), .ps2_data_in(pdata),
      .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.done) n_done++;
      if (bus.nack) n_nack++;
      if (bus.done && bus.nack) n_both++;
   end

   task automatic send(input logic [7:0] b);
      bus.tx_valid = 1;
      bus.tx_data  = b;
      @(negedge clk);
      bus.tx_valid = 0;
   endtask

   task automatic dev_frame(input logic ack, output logic [9:0] bits, output logic seen);
      seen = 0;
      bits = '0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = !clk_oe && data_oe;
      end
      if (seen) begin
         repeat (5) @(negedge clk);
         for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ~ack;
            repeat (5) @(negedge clk);
            dev_clk = 0;
            repeat (20) @(negedge clk);
            if (k <= 10) bits[k-1] = pdata;
            dev_clk  = 1;
            dev_data = 1;
            repeat (15) @(negedge clk);
         end
      end
   endtask

   task automatic watch(output int clk_lo, output int first, output int rdy_bad, output logic hit);
      clk_lo = 0; first = 0; rdy_bad = 0; hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         if (clk_oe) clk_lo++;
         if (data_oe && first == 0) first = clk_lo;
         if (bus.done || bus.nack) hit = 1;
         else begin
            if (bus.tx_ready) rdy_bad++;
            @(negedge clk);
         end
      end
   endtask

   task automatic frame(input logic [7:0] b, input logic ack, input logic poke, output logic [9:0] bits,
                        output int clk_lo, output int first, output int rdy_bad, output logic hit,
                        output logic seen);
      send(b);
      fork
         dev_frame(ack, bits, seen);
         watch(clk_lo, first, rdy_bad, hit);
         begin
            if (poke) begin
               repeat (200) @(negedge clk);
               bus.tx_valid = 1;
               bus.tx_data  = 8'h00;
               repeat (3) @(negedge clk);
               bus.tx_valid = 0;
            end
         end
      join
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.tx_ready, bus.busy, bus.done, bus.nack, clk_oe, data_oe} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_state got=%b exp=100000", {bus.tx_ready, bus.busy, bus.done, bus.nack, clk_oe, data_oe});
      end
      reset = 1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_send_ack;
      logic [9:0] bits; int lo, first, rb, d0, n0; logic hit, seen;
      d0 = n_done; n0 = n_nack;
      frame(8'hED, 1, 0, bits, lo, first, rb, hit, seen);
      checks++;
      if ({hit, seen} !== 2'b11) begin failures++; $display("FAIL ed_complete got=%b exp=11", {hit, seen}); end
      checks++;
      if (lo !== 101) begin failures++; $display("FAIL ed_clk_low got=%0d exp=101", lo); end
      checks++;
      if (first !== 100) begin failures++; $display("FAIL ed_start_bit got=%0d exp=100", first); end
      checks++;
      if (bits !== 10'h3ED) begin failures++; $display("FAIL ed_bits got=%h exp=3ed", bits); end
      checks++;
      if (n_done - d0 !== 1 || n_nack - n0 !== 0) begin
         failures++;
         $display("FAIL ed_pulses got=%0d/%0d exp=1/0", n_done - d0, n_nack - n0);
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] b1, b2; int lo, first, rb1, rb2, d0; logic hit, seen;
      d0 = n_done;
      frame(8'hF4, 1, 0, b1, lo, first, rb1, hit, seen);
      frame(8'h01, 1, 0, b2, lo, first, rb2, hit, seen);
      checks++;
      if (b1 !== 10'h2F4) begin failures++; $display("FAIL b2b_f4_bits got=%h exp=2f4", b1); end
      checks++;
      if (b2 !== 10'h201) begin failures++; $display("FAIL b2b_01_bits got=%h exp=201", b2); end
      checks++;
      if (rb1 !== 0 || rb2 !== 0) begin failures++; $display("FAIL b2b_ready_low got=%0d/%0d exp=0/0", rb1, rb2); end
      checks++;
      if (bus.tx_ready !== 1 || n_done - d0 !== 2) begin
         failures++;
         $display("FAIL b2b_end got=ready%b done%0d exp=ready1 done2", bus.tx_ready, n_done - d0);
      end
   endtask

   task automatic test_nack;
      logic [9:0] bits; int lo, first, rb, d0, n0; logic hit, seen;
      d0 = n_done; n0 = n_nack;
      frame(8'hFF, 0, 0, bits, lo, first, rb, hit, seen);
      checks++;
      if (bits !== 10'h3FF) begin failures++; $display("FAIL nack_bits got=%h exp=3ff", bits); end
      checks++;
      if (n_nack - n0 !== 1 || n_done - d0 !== 0) begin
         failures++;
         $display("FAIL nack_pulses got=%0d/%0d exp=1/0", n_nack - n0, n_done - d0);
      end
      checks++;
      if ({bus.tx_ready, bus.busy} !== 2'b10) begin failures++; $display("FAIL nack_idle got=%b exp=10", {bus.tx_ready, bus.busy}); end
   endtask

   task automatic test_mid_valid;
      logic [9:0] bits; int lo, first, rb, d0; logic hit, seen;
      d0 = n_done;
      frame(8'hA5, 1, 1, bits, lo, first, rb, hit, seen);
      repeat (20) @(negedge clk);
      checks++;
      if (bits !== 10'h3A5) begin failures++; $display("FAIL mid_bits got=%h exp=3a5", bits); end
      checks++;
      if (n_done - d0 !== 1 || bus.busy !== 0) begin
         failures++;
         $display("FAIL mid_single got=done%0d busy%b exp=done1 busy0", n_done - d0, bus.busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [9:0] bits; int d0, n0; logic seen;
      d0 = n_done; n0 = n_nack;
      send(8'h0F);
      fork
         dev_frame(1, bits, seen);
         begin
            int falls; logic prev, rel;
            falls = 0; rel = 0;
            for (int i = 0; i < 400 && !rel; i++) begin @(negedge clk); rel = !clk_oe && data_oe; end
            prev = pclk;
            for (int i = 0; i < 1000 && falls < 5; i++) begin
               @(negedge clk);
               if (prev && !pclk) falls++;
               prev = pclk;
            end
            repeat (5) @(negedge clk);
            checks++;
            if (data_oe !== 1) begin failures++; $display("FAIL rst_mid_d4 got=%b exp=1", data_oe); end
            #2 reset = 0;
            #1;
            checks++;
            if ({clk_oe, data_oe, bus.tx_ready} !== 3'b001) begin
               failures++;
               $display("FAIL rst_mid_async got=%b exp=001", {clk_oe, data_oe, bus.tx_ready});
            end
         end
      join
      @(negedge clk);
      reset = 1;
      repeat (10) @(negedge clk);
      checks++;
      if (n_done - d0 !== 0 || n_nack - n0 !== 0 || bus.tx_ready !== 1) begin
         failures++;
         $display("FAIL rst_mid_nopulse got=%0d/%0d/%b exp=0/0/1", n_done - d0, n_nack - n0, bus.tx_ready);
      end
   endtask

   task automatic test_timeout;
      int k, n0; logic got;
      n0 = n_nack; got = 0; k = 1;
      send(8'hC3);
      while (k <= 5000 && !got) begin
         if (bus.nack) got = 1;
         else begin @(negedge clk); k++; end
      end
`ifdef PS2_HOST_TX_TIMEOUT_EN
      checks++;
      if (got !== 1 || k - 1 !== 2000) begin failures++; $display("FAIL timeout_nack got=%b@%0d exp=1@2000", got, k - 1); end
      checks++;
      if ({clk_oe, data_oe, bus.tx_ready} !== 3'b001) begin
         failures++;
         $display("FAIL timeout_release got=%b exp=001", {clk_oe, data_oe, bus.tx_ready});
      end
`else
      checks++;
      if (bus.busy !== 1 || n_nack - n0 !== 0) begin
         failures++;
         $display("FAIL stuck_busy got=busy%b nack%0d exp=busy1 nack0", bus.busy, n_nack - n0);
      end
      checks++;
      if ({clk_oe, data_oe} !== 2'b01) begin failures++; $display("FAIL stuck_lines got=%b exp=01", {clk_oe, data_oe}); end
      reset = 0;
      @(negedge clk);
      reset = 1;
`endif
      repeat (5) @(negedge clk);
   endtask

   initial begin
      bus.tx_valid = 0;
      bus.tx_data  = 8'h00;
      test_reset;
      test_send_ack;
      test_back_to_back;
      test_nack;
      test_mid_valid;
      test_reset_mid;
      test_timeout;
      checks++;
      if (n_both !== 0) begin failures++; $display("FAIL done_nack_overlap got=%0d exp=0", n_both); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
